// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADD_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             bit_sum;
    logic             bit_carry;

    // Subtraction is a + ~b + ~cin, so the inversion happens once at load time.
    assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_carry = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res   <= {bit_sum, res[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= bit_carry;
                    cnt   <= cnt + 1'b1;
                    // On the last step, carry holds the carry into the MSB.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {bit_sum, res[WIDTH-1:1]};
                        cout  <= bit_carry;
`ifdef SERIAL_ADD_SUB_OVF_EN
                        ovf   <= carry ^ bit_carry;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed vector table plus reset-abort and back-to-back sequences.
`timescale 1ns/1ps
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[5];

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; start is presented for exactly one rising edge (E0).
    task automatic applyStimulus(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb, input logic c);
        sub   = s;
        a     = va;
        b     = vb;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; checks latency, busy length and optional sum hold.
    task automatic waitDone(input string tag, input logic check_hold, input logic [W-1:0] hold_val,
                            input logic inject);
        int   cyc      = 0;
        int   busy_cnt = 0;
        logic seen     = 1'b0;
        logic hold_ok  = 1'b1;
        while (!seen && cyc < 3 * W) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (check_hold && sum !== hold_val) hold_ok = 1'b0;
            end
            if (inject && cyc == 3) begin
                sub   = 1'b0;
                a     = 8'h01;
                b     = 8'h01;
                cin   = 1'b0;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(W + 1));
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        checkOutput({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        if (check_hold) checkOutput({tag, "_sum_hold"}, 32'(hold_ok), 32'd1);
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_SUB_OVF_EN
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("[TB] ovf not built");
`endif
    endtask

    initial begin
        int done_pulses;

        vecs[0] = '{"add_5A_33", 1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{"add_FF_01", 1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{"sub_10_20", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{"sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{"add_01_01", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkResult("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset four cycles into an add aborts it with no done pulse.
        applyStimulus(1'b0, 8'h5A, 8'h33, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkResult("abort", 8'h00, 1'b0, 1'b0);
        done_pulses = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (done) done_pulses++;
        end
        checkOutput("abort_no_done", 32'(done_pulses), 32'd0);
        checkOutput("abort_sum_zero", 32'(sum), 32'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
            waitDone(vecs[i].name, 1'b0, '0, 1'b0);
            checkResult(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
            @(negedge clk);
            checkOutput({vecs[i].name, "_done_pulse_width"}, 32'(done), 32'd0);
        end

        // Start mid-run is ignored, then start in the DONE cycle runs back-to-back.
        applyStimulus(1'b0, 8'h5A, 8'h33, 1'b0);
        waitDone("hs_first", 1'b0, '0, 1'b1);
        checkResult("hs_first", 8'h8D, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h01, 8'h01, 1'b0);
        waitDone("hs_second", 1'b1, 8'h8D, 1'b0);
        checkResult("hs_second", 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("hs_idle_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
